vec_feeder: RTL and testbench

VEC_FEEDER -- requirements
Module: vec_feeder

---
 rtl/vec_pkg.sv | 25 ++
 rtl/vec_feeder_if.sv | 22 ++
 rtl/res_fifo.sv | 54 +++++
 rtl/vec_mul.sv | 40 ++++
 rtl/vec_feeder.sv | 91 +++++++++
 tb/tb_vec_feeder.sv | 200 ++++++++++++++++++++
 6 files changed

// File: rtl/vec_pkg.sv
// Shared constants and width helpers for vec_feeder and the vec_mul pipeline it drives.
package vec_pkg;

  localparam int unsigned C_DEF         = 8;
  localparam int unsigned W_X_DEF       = 8;
  localparam int unsigned W_K_DEF       = 8;
  localparam int unsigned OUT_DEPTH_DEF = 4;

  function automatic int unsigned depth_of(input int unsigned c);
    return $clog2(c);
  endfunction

  function automatic int unsigned w_y_of(input int unsigned w_x, input int unsigned w_k,
                                         input int unsigned c);
    return w_x + w_k + $clog2(c);
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/vec_feeder_if.sv
// Element-stream input and result-stream output of vec_feeder.
interface vec_feeder_if
  import vec_pkg::*;
#(
  parameter int unsigned W_X = W_X_DEF,
  parameter int unsigned W_K = W_K_DEF,
  parameter int unsigned W_Y = w_y_of(W_X_DEF, W_K_DEF, C_DEF)
);
  logic                  s_valid;
  logic                  s_ready;
  logic signed [W_X-1:0] s_x;
  logic signed [W_K-1:0] s_k;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic signed [W_Y-1:0] m_y;

  modport slave  (input  s_valid, s_x, s_k, s_last, m_ready,
                  output s_ready, m_valid, m_y);
  modport master (output s_valid, s_x, s_k, s_last, m_ready,
                  input  s_ready, m_valid, m_y);
endinterface

// File: rtl/res_fifo.sv
// Small result FIFO; exposes its next-cycle occupancy so the parent can register credit.
module res_fifo #(
  parameter int unsigned W_Y       = 19,
  parameter int unsigned OUT_DEPTH = 4,
  localparam int unsigned CNT_W    = $clog2(OUT_DEPTH + 1),
  localparam int unsigned PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W_Y-1:0]   din,
  input  logic             pop,
  output logic [W_Y-1:0]   dout,
  output logic             valid,
  output logic [CNT_W-1:0] count_next_c
);
  logic [W_Y-1:0]   mem [OUT_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push_c, do_pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop_c     = pop && (count != '0);
    do_push_c    = push && ((count != CNT_W'(OUT_DEPTH)) || do_pop_c);
    count_next_c = count;
    if (do_push_c && !do_pop_c)      count_next_c = count + CNT_W'(1);
    else if (!do_push_c && do_pop_c) count_next_c = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop_c) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next_c;
      valid <= (count_next_c != '0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/vec_mul.sv
// Pipelined signed dot product: one product stage followed by a registered adder tree.
module vec_mul
  import vec_pkg::*;
#(
  parameter int unsigned C   = C_DEF,
  parameter int unsigned W_X = W_X_DEF,
  parameter int unsigned W_K = W_K_DEF,
  localparam int unsigned DEPTH = depth_of(C),
  localparam int unsigned W_Y   = w_y_of(W_X, W_K, C)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [C*W_X-1:0] x,
  input  logic signed [C*W_K-1:0] k,
  output logic signed [W_Y-1:0]   y
);
  logic signed [W_Y-1:0] prod_c [C];
  logic signed [W_Y-1:0] lvl    [DEPTH+1][C];

  always_comb begin
    for (int i = 0; i < C; i++)
      prod_c[i] = W_Y'($signed(x[i*W_X +: W_X])) * W_Y'($signed(k[i*W_K +: W_K]));
  end

  // Level 0 holds products; each further level halves the live lane count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l <= DEPTH; l++)
        for (int i = 0; i < C; i++) lvl[l][i] <= '0;
    end else begin
      for (int i = 0; i < C; i++) lvl[0][i] <= prod_c[i];
      for (int l = 1; l <= DEPTH; l++)
        for (int i = 0; i < (C >> l); i++)
          lvl[l][i] <= lvl[l-1][2*i] + lvl[l-1][2*i+1];
    end
  end

  assign y = lvl[DEPTH][0];

endmodule

// File: rtl/vec_feeder.sv
// Gathers streamed (x,k) elements into lane vectors for vec_mul and queues the returned
// dot products, admitting new beats only while a FIFO slot is reserved for every result.
module vec_feeder
  import vec_pkg::*;
#(
  parameter int unsigned C         = C_DEF,
  parameter int unsigned W_X       = W_X_DEF,
  parameter int unsigned W_K       = W_K_DEF,
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
  localparam int unsigned DEPTH    = depth_of(C),
  localparam int unsigned W_Y      = w_y_of(W_X, W_K, C)
) (
  input  logic                    clk,
  input  logic                    rst,
  vec_feeder_if.slave             bus,
  output logic signed [C*W_X-1:0] mul_x,
  output logic signed [C*W_K-1:0] mul_k,
  input  logic signed [W_Y-1:0]   mul_y
);
  localparam int unsigned CW    = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned TW    = DEPTH + 2;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]           cnt;
  logic [W_X-1:0]          stage_x [C];
  logic [W_K-1:0]          stage_k [C];
  logic [TW-1:0]           tags, tags_next_c;
  logic signed [C*W_X-1:0] issue_x_c;
  logic signed [C*W_K-1:0] issue_k_c;
  logic                    accept_c, done_c, s_ready_q;
  logic [CNT_W-1:0]        fifo_next_c;

  assign accept_c    = bus.s_valid && s_ready_q;
  assign done_c      = accept_c && (bus.s_last || (cnt == CW'(C - 1)));
  assign tags_next_c = {tags[TW-2:0], done_c};
  assign bus.s_ready = s_ready_q;

  // Issue image: staged lanes below cnt, live beat at cnt, zeros above.
  always_comb begin
    issue_x_c = '0;
    issue_k_c = '0;
    for (int i = 0; i < C; i++) begin
      if (CW'(i) < cnt) begin
        issue_x_c[i*W_X +: W_X] = stage_x[i];
        issue_k_c[i*W_K +: W_K] = stage_k[i];
      end else if (CW'(i) == cnt) begin
        issue_x_c[i*W_X +: W_X] = bus.s_x;
        issue_k_c[i*W_K +: W_K] = bus.s_k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      tags      <= '0;
      mul_x     <= '0;
      mul_k     <= '0;
      s_ready_q <= 1'b1;
      for (int i = 0; i < C; i++) begin
        stage_x[i] <= '0;
        stage_k[i] <= '0;
      end
    end else begin
      tags <= tags_next_c;
      // Ready for next cycle = its occupancy plus its in-flight results still below depth.
      s_ready_q <= (32'(fifo_next_c) + popcount(32'(tags_next_c))) < OUT_DEPTH;
      if (accept_c) begin
        stage_x[cnt] <= bus.s_x;
        stage_k[cnt] <= bus.s_k;
        cnt          <= done_c ? '0 : cnt + CW'(1);
      end
      if (done_c) begin
        mul_x <= issue_x_c;
        mul_k <= issue_k_c;
      end
    end
  end

  res_fifo #(.W_Y(W_Y), .OUT_DEPTH(OUT_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (tags[TW-1]),
    .din          (mul_y),
    .pop          (bus.m_ready),
    .dout         (bus.m_y),
    .valid        (bus.m_valid),
    .count_next_c (fifo_next_c)
  );

endmodule

// File: tb/tb_vec_feeder.sv
// Directed bench: vec_feeder feeding a vec_mul instance, results checked against hand sums.
module tb_vec_feeder;
  import vec_pkg::*;

  localparam int unsigned C         = 8;
  localparam int unsigned W_X       = 8;
  localparam int unsigned W_K       = 8;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned W_Y       = w_y_of(W_X, W_K, C);

  logic                    clk, rst;
  logic signed [C*W_X-1:0] mul_x;
  logic signed [C*W_K-1:0] mul_k;
  logic signed [W_Y-1:0]   mul_y;
  int                      total, bad;
  logic signed [W_Y-1:0]   got [$];

  vec_feeder_if #(.W_X(W_X), .W_K(W_K), .W_Y(W_Y)) bus ();

  vec_feeder #(.C(C), .W_X(W_X), .W_K(W_K), .OUT_DEPTH(OUT_DEPTH)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_x (mul_x),
    .mul_k (mul_k),
    .mul_y (mul_y)
  );

  vec_mul #(.C(C), .W_X(W_X), .W_K(W_K)) u_mul (
    .clk (clk),
    .rst (rst),
    .x   (mul_x),
    .k   (mul_k),
    .y   (mul_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every result handshake mid-cycle.
  always @(negedge clk) if (!rst && bus.m_valid && bus.m_ready) got.push_back(bus.m_y);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [W_X-1:0] x, input logic signed [W_K-1:0] k,
                      input logic last);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_x     = x;
    bus.s_k     = k;
    bus.s_last  = last;
    while (!bus.s_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("send_timeout", 64'(bus.s_ready), 1);
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic signed [63:0] exp);
    int n = 0;
    while (!bus.m_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.m_valid), 1);
    chk(tag, bus.m_y, exp);
    step();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    bus.s_valid = 1'b0;
    bus.s_x     = '0;
    bus.s_k     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(bus.m_valid), 0);
    chk("rst_m_y", bus.m_y, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_k", mul_k, 0);
    rst = 1'b0;
    step();
    chk("rst_s_ready", 64'(bus.s_ready), 1);

    // Full vector x=1..8, k=1: 36 after exactly five cycles.
    for (int i = 1; i <= 4; i++) send(8'(i), 8'sd1, 1'b0);
    chk("stage_no_issue", mul_x, 0);
    for (int i = 5; i <= 8; i++) send(8'(i), 8'sd1, 1'b0);
    chk("full_mul_x", mul_x, 64'h0807060504030201);
    chk("full_mul_k", mul_k, 64'h0101010101010101);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("full_latency_low", 64'(bus.m_valid), 0);
    end
    step();
    chk("full_latency_high", 64'(bus.m_valid), 1);
    chk("full_m_y", bus.m_y, 36);
    step();
    chk("full_popped", 64'(bus.m_valid), 0);

    // Short vector: upper lanes must be zero even though staging still holds 4..8.
    send(8'sd2, 8'sd5, 1'b0);
    send(8'sd3, 8'sd6, 1'b0);
    send(8'sd4, 8'sd7, 1'b1);
    chk("short_mul_x", mul_x, 64'h0000000000040302);
    chk("short_mul_k", mul_k, 64'h0000000000070605);
    wait_result("short_m_y", 56);

    // Signed extremes; the first vector also carries s_last on lane 7.
    for (int i = 0; i < 8; i++) send(8'sh80, 8'sh80, 1'(i == 7));
    wait_result("neg_neg", 131072);
    for (int i = 0; i < 8; i++) send(8'sh80, 8'sd127, 1'b0);
    wait_result("neg_pos", -130048);

    // Credit exhaustion with the result side stalled.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 8'(i + 1), 1'b1);
    chk("credit_exhausted", 64'(bus.s_ready), 0);
    bus.s_valid = 1'b1;
    bus.s_x     = 8'sd5;
    bus.s_k     = 8'sd6;
    bus.s_last  = 1'b1;
    repeat (8) step();
    chk("credit_held", 64'(bus.s_ready), 0);
    chk("credit_r1", bus.m_y, 2);
    bus.m_ready = 1'b1;
    step();
    chk("credit_back", 64'(bus.s_ready), 1);
    chk("credit_r2", bus.m_y, 6);
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("credit_r3", bus.m_y, 12);
    step();
    chk("credit_r4", bus.m_y, 20);
    step();
    wait_result("credit_r5", 30);
    repeat (6) step();
    chk("credit_no_extra", 64'(bus.m_valid), 0);

    // Reset with one result in flight and a partial vector staged.
    send(8'sd9, 8'sd9, 1'b1);
    send(8'sd1, 8'sd1, 1'b0);
    send(8'sd2, 8'sd2, 1'b0);
    send(8'sd3, 8'sd3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 64'(bus.m_valid), 0);
    chk("mid_rst_mul_x", mul_x, 0);
    chk("mid_rst_s_ready", 64'(bus.s_ready), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("rst_flush", 64'(bus.m_valid), 0);
      step();
    end
    for (int i = 1; i <= 8; i++) send(8'(i), 8'sd2, 1'b0);
    wait_result("post_rst", 72);
    repeat (6) step();
    chk("post_rst_no_extra", 64'(bus.m_valid), 0);

    // Back-to-back single-element vectors: order and count preserved.
    got.delete();
    for (int i = 0; i < 12; i++) send(8'(i + 1), 8'sd3, 1'b1);
    for (int n = 0; n < 60 && got.size() < 12; n++) step();
    repeat (6) step();
    chk("stream_count", 64'(got.size()), 12);
    for (int i = 0; i < 12 && i < got.size(); i++) chk("stream_y", got[i], 3 * (i + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
